// File: rtl/rf_pkg.sv
// Shared constants for the register file and its dump engine.
package rf_pkg;

  // Default geometry; the Datapath top reuses these.
  localparam int RF_DATA_W = 32;
  localparam int RF_DEPTH  = 32;

  // Dump FSM encoding.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

endpackage

// File: rtl/rf_dump_fsm.sv
// Dump engine: walks every register index and presents each one as a
// valid/ready beat. Data is captured from a dedicated read port of the
// storage when an index is loaded, so it stays frozen while the consumer stalls.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for dump_start; read port aimed at index 0
// ST_STREAM | beat dump_addr presented; read port aimed at dump_addr+1
// ST_DONE   | last beat accepted; dump_done high for this single cycle
module rf_dump_fsm
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dump_start,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] rd_idx,
  input  logic [DATA_W-1:0] rd_data,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_busy,
  output logic              dump_done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [1:0] state;
  logic       beat_acc;

  assign beat_acc  = dump_valid & dump_ready;
  assign dump_busy = (state != ST_IDLE);

  // Look ahead one index so the next beat's data is ready at the accepting edge.
  assign rd_idx = (state == ST_STREAM) ? dump_addr + ADDR_W'(1) : '0;

  // Sequence IDLE -> STREAM -> DONE and register each beat at load time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
      dump_done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          dump_done <= 1'b0;
          if (dump_start) begin
            state      <= ST_STREAM;
            dump_valid <= 1'b1;
            dump_addr  <= '0;
            dump_data  <= rd_data;
          end
        end
        ST_STREAM: begin
          if (beat_acc) begin
            if (dump_addr == LAST_IDX) begin
              state      <= ST_DONE;
              dump_valid <= 1'b0;
              dump_done  <= 1'b1;
            end else begin
              dump_addr <= dump_addr + ADDR_W'(1);
              dump_data <= rd_data;
            end
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          dump_done <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          dump_valid <= 1'b0;
          dump_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/regfile_scan.sv
// Parametrised multi-read-port register file with a streaming dump engine.
// Storage is never cleared by reset so a hierarchical preload of regArray
// survives the reset sequence.
module regfile_scan
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic                     dump_start,
  input  logic                     dump_ready,
  output logic                     dump_valid,
  output logic [ADDR_W-1:0]        dump_addr,
  output logic [DATA_W-1:0]        dump_data,
  output logic                     dump_busy,
  output logic                     dump_done
);

  logic [DATA_W-1:0] regArray [DEPTH];

  logic [ADDR_W-1:0] dump_rd_idx;
  logic [DATA_W-1:0] dump_rd_data;

  // An index is backed by storage when it is in range and not the hardwired zero.
  function automatic logic idx_live(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W + 1)'(DEPTH)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Write port; dead indices silently drop the write.
  always_ff @(posedge clk) begin
    if (we && idx_live(waddr)) begin
      regArray[waddr] <= wdata;
    end
  end

  // Asynchronous read ports, no write bypass.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = raddr[p*ADDR_W +: ADDR_W];
    assign rdata[p*DATA_W +: DATA_W] = idx_live(ra) ? regArray[ra] : '0;
  end

  // Private read port owned by the dump engine.
  assign dump_rd_data = idx_live(dump_rd_idx) ? regArray[dump_rd_idx] : '0;

  rf_dump_fsm #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_dump (
    .clk        (clk),
    .reset      (reset),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .rd_idx     (dump_rd_idx),
    .rd_data    (dump_rd_data),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done)
  );

endmodule
